knn_topk_scheduler: RTL and testbench
=====================================

# knn_topk_scheduler

Controller that owns the 8-lane bitonic top-4 sorter and uses it to keep the running 4 nearest candidates for one query patch. It collects streamed (distance, index) candidates four at a time and issues each group to the sorter together with the current best-4. It waits out the sorter latency, captures the new best-4, and presents the final ascending top-4 per query on a valid/ready result port. It sits between the leaf-distance computation and the result writeback.

## Interface
- DATA_W, 25, distance width (matches sorter data lanes)
- IDX_W, 15, candidate index width
- SORT_LAT, 6, sorter latency in cycles, valid_in to valid_out
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- cand_valid  input  1  candidate present
- cand_ready  output  1  candidate accepted when cand_valid && cand_ready
- cand_data  input  DATA_W  candidate distance
- cand_idx  input  IDX_W  candidate index
- cand_last  input  1  final candidate of current query
- sort_valid_in  output  1  one-cycle issue strobe to sorter
- sort_data_in  output  8*DATA_W  lane i at [i*DATA_W +: DATA_W]
- sort_idx_in  output  8*IDX_W  lane i at [i*IDX_W +: IDX_W]
- sort_valid_out  input  1  sorter result strobe
- sort_data_out  input  4*DATA_W  sorter ascending top-4, lane 0 smallest
- sort_idx_out  input  4*IDX_W  matching indices
- res_valid  output  1  final top-4 available
- res_ready  input  1  consumer accepts result
- res_data  output  4*DATA_W  ascending distances, lane 0 smallest
- res_idx  output  4*IDX_W  matching indices
- busy  output  1  high in any state except COLLECT with 0 slots filled

## Operation
- Reset values:
  - state COLLECT, slot count 0, last_seen 0.
  - Best-4 data all-ones (PAD), best-4 idx 0.
  - All sort_* and res_* outputs 0; cand_ready 1; busy 0.
- COLLECT:
  - cand_ready = 1.
  - Each accepted candidate is written to slot[count], and count is incremented.
  - If count reaches 4 or cand_last is accepted, go to ISSUE. cand_last is latched into last_seen.
- ISSUE (1 cycle):
  - sort_valid_in = 1.
  - Lanes 0-3 carry slots 0-3. Unfilled slots carry data PAD and idx 0.
  - Lanes 4-7 carry best 0-3.
  - Next state is WAIT; count is cleared.
- WAIT:
  - cand_ready = 0.
  - On sort_valid_out, load best 0-3 from sort_data_out/sort_idx_out.
  - Then go to DONE if last_seen, else COLLECT.
- DONE:
  - res_valid = 1; res_data/res_idx = best, held stable.
  - On res_valid && res_ready: reset best to PAD/0, clear last_seen, go to COLLECT.
- Ignored inputs: sort_valid_out outside WAIT is ignored, as are candidates outside COLLECT.
- Result semantics: lanes with data PAD are empty. A query with fewer than 4 candidates returns PAD/0 in its upper lanes.
- Ties: order among equal distances is whatever the sorter produces. The scheduler imposes no order.

## Timing
- sort_* outputs are registered. sort_valid_in is high exactly one cycle per group, and never again until the result returns, so there is at most one group in flight.
- If sort_valid_in is high in cycle t, sort_valid_out arrives in cycle t+SORT_LAT. Best is updated at the end of that cycle, and the state is COLLECT or DONE in t+SORT_LAT+1.
- A full group of 4 costs 4 accept cycles + 1 ISSUE + SORT_LAT WAIT cycles = 11 cycles at defaults.
- cand_ready drops the cycle after the 4th accept or the cand_last accept. It reasserts the cycle after capture, or the cycle after the result handshake.
- cand_last on the 4th slot produces a single issue; there is no extra pad group.
- The res_valid handshake follows the standard rule: data is held while res_ready is low. With res_ready tied high, res_valid is high for 1 cycle.
- Reset asserted mid-operation:
  - All state clears immediately.
  - A sorter result arriving after reset is ignored, because the state is COLLECT.

## Test plan
- 4 candidates (50,1),(10,2),(40,3),(30,4), last on 4th -> one sort_valid_in pulse with lanes 4-7 PAD. Result data 10,30,40,50, idx 2,4,3,1, with res_valid exactly 7 cycles after the issue cycle.
- 6 candidates with data 9,8,7,6,5,4 and idx 1-6, last on 6th -> two issues. The second issue has lanes 2-3 PAD and lanes 4-7 = 6,7,8,9. Result data 4,5,6,7, idx 6,5,4,3.
- 2 candidates (20,1),(5,2), last on 2nd -> result data 5,20,PAD,PAD, idx 2,1,0,0.
- Result backpressure: hold res_ready low for 10 cycles with cand_valid high -> res_valid and res_data stay stable and cand_ready stays 0. Releasing res_ready gives one handshake, and the next query then starts with best reset to PAD.
- Assert rst during WAIT, release it, then drive the sorter's stale sort_valid_out -> the stale result is ignored. A following query of 1 candidate (3,7) returns 3,PAD,PAD,PAD with idx 7,0,0,0.
- cand_valid with random gaps plus a spurious sort_valid_out pulse in COLLECT -> no state change from the pulse and no dropped candidates. Result matches a software top-4 over 32 random candidates.

Source files
------------

// File: rtl/knn_topk_scheduler.sv
// Running best-4 scheduler for one query: batches candidates in fours,
// merges each batch with the current best-4 through the bitonic top-4 sorter.
module knn_topk_scheduler #(
  parameter int DATA_W   = 25,
  parameter int IDX_W    = 15,
  parameter int SORT_LAT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cand_valid,
  output logic                cand_ready,
  input  logic [DATA_W-1:0]   cand_data,
  input  logic [IDX_W-1:0]    cand_idx,
  input  logic                cand_last,
  output logic                sort_valid_in,
  output logic [8*DATA_W-1:0] sort_data_in,
  output logic [8*IDX_W-1:0]  sort_idx_in,
  input  logic                sort_valid_out,
  input  logic [4*DATA_W-1:0] sort_data_out,
  input  logic [4*IDX_W-1:0]  sort_idx_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*DATA_W-1:0] res_data,
  output logic [4*IDX_W-1:0]  res_idx,
  output logic                busy
);

  typedef enum logic [1:0] {
    COLLECT,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [DATA_W-1:0] PAD = '1;

  state_t state, state_n;

  logic [2:0]        count;
  logic              last_seen;
  logic [DATA_W-1:0] slot_d [4];
  logic [IDX_W-1:0]  slot_i [4];
  logic [DATA_W-1:0] best_d [4];
  logic [IDX_W-1:0]  best_i [4];
  logic [7:0]        wait_cnt;

  logic accept;
  logic capture;
  logic res_fire;

  assign accept   = (state == COLLECT) && cand_valid;
  assign capture  = (state == WAIT) && sort_valid_out;
  assign res_fire = (state == DONE) && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      COLLECT: begin
        if (accept && (count == 3'd3 || cand_last))
          state_n = ISSUE;
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (sort_valid_out)
          state_n = last_seen ? DONE : COLLECT;
      end
      DONE: begin
        if (res_ready) state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      last_seen <= 1'b0;
      wait_cnt  <= '0;
      for (int i = 0; i < 4; i++) begin
        slot_d[i] <= PAD;
        slot_i[i] <= '0;
        best_d[i] <= PAD;
        best_i[i] <= '0;
      end
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
      if (accept) begin
        slot_d[count[1:0]] <= cand_data;
        slot_i[count[1:0]] <= cand_idx;
        count              <= count + 3'd1;
        if (cand_last) last_seen <= 1'b1;
      end
      // Slots return to PAD so a short final group pads itself.
      if (state == ISSUE) begin
        count <= '0;
        for (int i = 0; i < 4; i++) begin
          slot_d[i] <= PAD;
          slot_i[i] <= '0;
        end
      end
      if (capture) begin
        for (int i = 0; i < 4; i++) begin
          best_d[i] <= sort_data_out[i*DATA_W +: DATA_W];
          best_i[i] <= sort_idx_out[i*IDX_W +: IDX_W];
        end
      end
      if (res_fire) begin
        last_seen <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          best_d[i] <= PAD;
          best_i[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    sort_valid_in = (state == ISSUE);
    sort_data_in  = '0;
    sort_idx_in   = '0;
    if (state == ISSUE) begin
      for (int i = 0; i < 4; i++) begin
        sort_data_in[i*DATA_W +: DATA_W]     = slot_d[i];
        sort_idx_in[i*IDX_W +: IDX_W]        = slot_i[i];
        sort_data_in[(i+4)*DATA_W +: DATA_W] = best_d[i];
        sort_idx_in[(i+4)*IDX_W +: IDX_W]    = best_i[i];
      end
    end
  end

  always_comb begin
    res_valid = (state == DONE);
    res_data  = '0;
    res_idx   = '0;
    if (state == DONE) begin
      for (int i = 0; i < 4; i++) begin
        res_data[i*DATA_W +: DATA_W] = best_d[i];
        res_idx[i*IDX_W +: IDX_W]    = best_i[i];
      end
    end
  end

  assign cand_ready = (state == COLLECT);
  assign busy       = !((state == COLLECT) && (count == 3'd0));

  // The sorter answers a fixed number of cycles after the issue strobe.
  a_sort_lat: assert property (@(posedge clk) disable iff (rst)
    capture |-> wait_cnt == 8'(SORT_LAT - 1));

endmodule

// File: tb/tb_knn_topk_scheduler.sv
// Directed and table-driven bench for knn_topk_scheduler with a
// behavioural top-4 sorter model answering after SORT_LAT cycles.
module tb_knn_topk_scheduler;

  localparam int DW  = 25;
  localparam int IW  = 15;
  localparam int SL  = 6;
  localparam int PAD = (1 << DW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            cand_valid;
  logic            cand_ready;
  logic [DW-1:0]   cand_data;
  logic [IW-1:0]   cand_idx;
  logic            cand_last;
  logic            sort_valid_in;
  logic [8*DW-1:0] sort_data_in;
  logic [8*IW-1:0] sort_idx_in;
  logic            sort_valid_out;
  logic [4*DW-1:0] sort_data_out;
  logic [4*IW-1:0] sort_idx_out;
  logic            res_valid;
  logic            res_ready;
  logic [4*DW-1:0] res_data;
  logic [4*IW-1:0] res_idx;
  logic            busy;

  knn_topk_scheduler #(.DATA_W(DW), .IDX_W(IW), .SORT_LAT(SL)) dut (
    .clk(clk), .rst(rst),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_data(cand_data), .cand_idx(cand_idx), .cand_last(cand_last),
    .sort_valid_in(sort_valid_in), .sort_data_in(sort_data_in),
    .sort_idx_in(sort_idx_in), .sort_valid_out(sort_valid_out),
    .sort_data_out(sort_data_out), .sort_idx_out(sort_idx_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntot = 0;
  int npass = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    ntot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      npass++;
  endtask

  // Sorter model
  logic            mv = 1'b0;
  logic            spur_v = 1'b0;
  logic [4*DW-1:0] md = '0;
  logic [4*IW-1:0] mi = '0;
  logic [8*DW-1:0] iss_q[$];
  int              iss_cyc = 0;

  assign sort_valid_out = mv | spur_v;
  assign sort_data_out  = spur_v ? '0 : md;
  assign sort_idx_out   = spur_v ? {4{15'h7fff}} : mi;

  always @(negedge clk) begin
    if (sort_valid_in) begin
      int ld[8];
      int li[8];
      int t;
      iss_q.push_back(sort_data_in);
      iss_cyc = cyc;
      for (int i = 0; i < 8; i++) begin
        ld[i] = int'(sort_data_in[i*DW +: DW]);
        li[i] = int'(sort_idx_in[i*IW +: IW]);
      end
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 8; j++)
          if (ld[j] < ld[i]) begin
            t = ld[i]; ld[i] = ld[j]; ld[j] = t;
            t = li[i]; li[i] = li[j]; li[j] = t;
          end
      repeat (SL) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        md[i*DW +: DW] = DW'(ld[i]);
        mi[i*IW +: IW] = IW'(li[i]);
      end
      mv = 1'b1;
      @(posedge clk);
      #1 mv = 1'b0;
    end
  end

  task automatic send(int d, int ix, bit last);
    int n = 0;
    cand_valid = 1'b1;
    cand_data  = DW'(d);
    cand_idx   = IW'(ix);
    cand_last  = last;
    @(negedge clk);
    while (!cand_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      ntot++;
      $display("FAIL send_timeout: cand_ready low for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    cand_valid = 1'b0;
    cand_last  = 1'b0;
  endtask

  task automatic get_res(output logic [4*DW-1:0] d,
                         output logic [4*IW-1:0] ix, output int c);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      ntot++;
      $display("FAIL res_timeout: res_valid low for %0d cycles, required 1", n);
    end
    d  = res_data;
    ix = res_idx;
    c  = cyc;
    if (res_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int n;
    int ni;
    int d[8];
    int ix[8];
    int ed[4];
    int ei[4];
  } vec_t;

  vec_t v[4];

  logic [4*DW-1:0] rd, ed;
  logic [4*IW-1:0] ri, ei;
  int              rc;

  initial begin : main
    int bad;
    int saw;
    int sbusy;
    int qd[32];
    int qi[32];
    int t;
    logic [4*DW-1:0] d0;

    v[0].n = 4; v[0].ni = 1;
    v[0].d  = '{50, 10, 40, 30, 0, 0, 0, 0};
    v[0].ix = '{1, 2, 3, 4, 0, 0, 0, 0};
    v[0].ed = '{10, 30, 40, 50};
    v[0].ei = '{2, 4, 3, 1};
    v[1].n = 6; v[1].ni = 2;
    v[1].d  = '{9, 8, 7, 6, 5, 4, 0, 0};
    v[1].ix = '{1, 2, 3, 4, 5, 6, 0, 0};
    v[1].ed = '{4, 5, 6, 7};
    v[1].ei = '{6, 5, 4, 3};
    v[2].n = 2; v[2].ni = 1;
    v[2].d  = '{20, 5, 0, 0, 0, 0, 0, 0};
    v[2].ix = '{1, 2, 0, 0, 0, 0, 0, 0};
    v[2].ed = '{5, 20, PAD, PAD};
    v[2].ei = '{2, 1, 0, 0};
    v[3].n = 8; v[3].ni = 2;
    v[3].d  = '{1, 2, 3, 4, 100, 200, 300, 400};
    v[3].ix = '{11, 12, 13, 14, 15, 16, 17, 18};
    v[3].ed = '{1, 2, 3, 4};
    v[3].ei = '{11, 12, 13, 14};

    rst = 1'b1;
    cand_valid = 1'b0; cand_data = '0; cand_idx = '0; cand_last = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cand_ready", cand_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_sort_valid", sort_valid_in, 0);
    chk("rst_sort_data", sort_data_in, 0);
    chk("rst_res_data", res_data, 0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 4; k++) begin
      iss_q.delete();
      for (int j = 0; j < v[k].n; j++)
        send(v[k].d[j], v[k].ix[j], j == v[k].n - 1);
      get_res(rd, ri, rc);
      for (int i = 0; i < 4; i++) begin
        ed[i*DW +: DW] = DW'(v[k].ed[i]);
        ei[i*IW +: IW] = IW'(v[k].ei[i]);
      end
      chk($sformatf("vec%0d_data", k), rd, ed);
      chk($sformatf("vec%0d_idx", k), ri, ei);
      chk($sformatf("vec%0d_issues", k), iss_q.size(), v[k].ni);
      if (k == 0) begin
        chk("vec0_upper_pad", iss_q[0][4*DW +: 4*DW], {4{25'h1ffffff}});
        chk("vec0_latency", rc - iss_cyc, 7);
      end
      if (k == 1) begin
        chk("vec1_iss2_low", iss_q[1][0 +: 2*DW], {25'd4, 25'd5});
        chk("vec1_iss2_pad", iss_q[1][2*DW +: 2*DW], {2{25'h1ffffff}});
        chk("vec1_iss2_best", iss_q[1][4*DW +: 4*DW],
            {25'd9, 25'd8, 25'd7, 25'd6});
      end
    end

    // Result backpressure
    res_ready = 1'b0;
    send(7, 1, 1'b1);
    cand_valid = 1'b1; cand_data = 25'd99; cand_idx = 15'd9; cand_last = 1'b1;
    get_res(d0, ri, rc);
    chk("bp_data", d0, {25'h1ffffff, 25'h1ffffff, 25'h1ffffff, 25'd7});
    chk("bp_idx", ri, {15'd0, 15'd0, 15'd0, 15'd1});
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== d0 ||
          cand_ready !== 1'b0 || busy !== 1'b1)
        bad++;
    end
    chk("bp_stable", bad, 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_after_valid", res_valid, 0);
    chk("bp_after_ready", cand_ready, 1);
    @(posedge clk);
    #1;
    cand_valid = 1'b0; cand_last = 1'b0;
    get_res(rd, ri, rc);
    chk("bp_next_data", rd, {25'h1ffffff, 25'h1ffffff, 25'h1ffffff, 25'd99});
    chk("bp_next_idx", ri, {15'd0, 15'd0, 15'd0, 15'd9});

    // Reset during WAIT, stale sorter result afterwards
    for (int k = 0; k < 4; k++) send(k + 1, k + 1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", cand_ready, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    saw = 0;
    sbusy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sort_valid_out) begin
        saw = 1;
        if (busy) sbusy = 1;
      end
    end
    chk("stale_seen", saw, 1);
    chk("stale_busy", sbusy, 0);
    @(posedge clk);
    #1;
    send(3, 7, 1'b1);
    get_res(rd, ri, rc);
    chk("postrst_data", rd, {25'h1ffffff, 25'h1ffffff, 25'h1ffffff, 25'd3});
    chk("postrst_idx", ri, {15'd0, 15'd0, 15'd0, 15'd7});

    // Random stream with gaps and spurious sorter pulses
    for (int k = 0; k < 32; k++) begin
      qd[k] = int'($urandom_range(0, 999)) * 64 + k;
      qi[k] = 100 + k;
    end
    iss_q.delete();
    for (int k = 0; k < 32; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      if (k == 2 || k == 18) begin
        spur_v = 1'b1;
        @(posedge clk);
        #1 spur_v = 1'b0;
      end
      send(qd[k], qi[k], k == 31);
    end
    get_res(rd, ri, rc);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 32; j++)
        if (qd[j] < qd[i]) begin
          t = qd[i]; qd[i] = qd[j]; qd[j] = t;
          t = qi[i]; qi[i] = qi[j]; qi[j] = t;
        end
    for (int i = 0; i < 4; i++) begin
      ed[i*DW +: DW] = DW'(qd[i]);
      ei[i*IW +: IW] = IW'(qi[i]);
    end
    chk("rand_data", rd, ed);
    chk("rand_idx", ri, ei);
    chk("rand_issues", iss_q.size(), 8);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed",
             npass, ntot);
    $fatal(1);
  end

endmodule
